// File: rtl/demux18_loader_pkg.sv
// Shared definitions for the 8-slot nibble selection path (loader and downstream selector).
package demux18_loader_pkg;

  localparam int unsigned SLOTS     = 8;
  localparam int unsigned PTR_W     = 3;
  localparam int unsigned DEF_WIDTH = 4;

  // Slot encoding agreed with the downstream 8:1 selector: 3'b000 = D0 ... 3'b111 = D7.
  typedef logic [PTR_W-1:0] slot_idx_t;

  localparam slot_idx_t LAST_SLOT = slot_idx_t'(SLOTS - 1);

endpackage

// File: rtl/dec38_we.sv
// 3-to-8 one-hot write-enable decoder, gated by the effective write enable.
module dec38_we
  import demux18_loader_pkg::*;
(
  input  logic             en,
  input  slot_idx_t        addr,
  output logic [SLOTS-1:0] we
);

  always_comb begin
    we = '0;
    if (en) begin
      we[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/demux18_loader.sv
// Writer side of the 8-slot selection path: shadow bank collects writes, output bank
// D0..D7 changes only on commit so the downstream selector never sees a partial frame.
module demux18_loader
  import demux18_loader_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             wr_auto,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             commit,
  input  logic             clear,
  output logic [WIDTH-1:0] D0,
  output logic [WIDTH-1:0] D1,
  output logic [WIDTH-1:0] D2,
  output logic [WIDTH-1:0] D3,
  output logic [WIDTH-1:0] D4,
  output logic [WIDTH-1:0] D5,
  output logic [WIDTH-1:0] D6,
  output logic [WIDTH-1:0] D7,
  output logic [2:0]       ptr,
  output logic             dirty,
  output logic             frame_done
);

  logic [WIDTH-1:0] shadow_q [SLOTS];
  logic [WIDTH-1:0] shadow_d [SLOTS];
  logic [WIDTH-1:0] out_q    [SLOTS];
  slot_idx_t        ptr_q, ptr_d;
  logic             dirty_q, dirty_d;
  logic             frame_done_q;

  logic             wr_eff;
  logic             auto_end;
  logic             do_commit;
  slot_idx_t        target;
  logic [SLOTS-1:0] slot_we;

  assign wr_eff    = wr_en & ~clear;
  assign target    = wr_auto ? ptr_q : slot_idx_t'(wr_addr);
  assign auto_end  = wr_eff & wr_auto & (ptr_q == LAST_SLOT);
  assign do_commit = commit | auto_end;

  dec38_we u_dec (
    .en   (wr_eff),
    .addr (target),
    .we   (slot_we)
  );

  // shadow_d is both the next shadow state and the commit source, which gives the
  // same-edge write-through and the clear+commit -> RESET_VAL behaviour for free.
  always_comb begin
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (clear) begin
        shadow_d[i] = RESET_VAL;
      end else if (slot_we[i]) begin
        shadow_d[i] = wr_data;
      end else begin
        shadow_d[i] = shadow_q[i];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (wr_eff && wr_auto) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_comb begin
    dirty_d = dirty_q;
    if (do_commit) begin
      dirty_d = 1'b0;
    end else if (clear || wr_eff) begin
      dirty_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        shadow_q[i] <= RESET_VAL;
        out_q[i]    <= RESET_VAL;
      end
      ptr_q        <= '0;
      dirty_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        shadow_q[i] <= shadow_d[i];
        if (do_commit) begin
          out_q[i] <= shadow_d[i];
        end
      end
      ptr_q        <= ptr_d;
      dirty_q      <= dirty_d;
      frame_done_q <= do_commit;
    end
  end

  assign D0         = out_q[0];
  assign D1         = out_q[1];
  assign D2         = out_q[2];
  assign D3         = out_q[3];
  assign D4         = out_q[4];
  assign D5         = out_q[5];
  assign D6         = out_q[6];
  assign D7         = out_q[7];
  assign ptr        = ptr_q;
  assign dirty      = dirty_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_demux18_loader.sv
// Directed self-checking bench for demux18_loader.
module tb_demux18_loader;

  logic       clk = 1'b0;
  logic       rst, wr_en, wr_auto, commit, clear;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] D0, D1, D2, D3, D4, D5, D6, D7;
  logic [2:0] ptr;
  logic       dirty, frame_done;
  logic [31:0] dvec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux18_loader #(.WIDTH(4), .RESET_VAL(4'h0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_auto(wr_auto), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit(commit), .clear(clear),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5), .D6(D6), .D7(D7),
    .ptr(ptr), .dirty(dirty), .frame_done(frame_done)
  );

  assign dvec = {D7, D6, D5, D4, D3, D2, D1, D0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; wr_en = 1'b0; wr_auto = 1'b0; wr_addr = 3'd0;
    wr_data = 4'd0; commit = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (dvec !== 32'h0) begin errors++; $display("FAIL reset_D got %h exp %h", dvec, 32'h0); end
    checks++; if (ptr !== 3'd0) begin errors++; $display("FAIL reset_ptr got %0d exp 0", ptr); end
    checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL reset_dirty got %b exp 0", dirty); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b exp 0", frame_done); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (dvec !== 32'h0 || ptr !== 3'd0 || dirty !== 1'b0 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL idle_%0d got D=%h ptr=%0d dirty=%b fd=%b exp all zero", i, dvec, ptr, dirty, frame_done);
      end
    end
  endtask

  task automatic test_auto_frame();
    for (int k = 0; k < 8; k++) begin
      wr_en = 1'b1; wr_auto = 1'b1; wr_addr = 3'd6; wr_data = 4'(k + 1);
      tick();
      if (k < 7) begin
        checks++;
        if (dvec !== 32'h0 || dirty !== 1'b1 || ptr !== 3'(k + 1) || frame_done !== 1'b0) begin
          errors++;
          $display("FAIL auto_w%0d got D=%h dirty=%b ptr=%0d fd=%b exp D=0 dirty=1 ptr=%0d fd=0",
                   k, dvec, dirty, ptr, frame_done, k + 1);
        end
      end
    end
    idle_inputs();
    checks++; if (dvec !== 32'h87654321) begin errors++; $display("FAIL auto_D got %h exp 87654321", dvec); end
    checks++; if (ptr !== 3'd0) begin errors++; $display("FAIL auto_ptr got %0d exp 0", ptr); end
    checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL auto_dirty got %b exp 0", dirty); end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL auto_fd got %b exp 1", frame_done); end
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL auto_fd_pulse got %b exp 0", frame_done); end
    checks++; if (dvec !== 32'h87654321) begin errors++; $display("FAIL auto_hold got %h exp 87654321", dvec); end
  endtask

  task automatic test_addr_commit();
    wr_en = 1'b1; wr_auto = 1'b0; wr_addr = 3'd5; wr_data = 4'hA;
    tick();
    idle_inputs();
    checks++; if (dvec !== 32'h87654321) begin errors++; $display("FAIL addr_hold got %h exp 87654321", dvec); end
    checks++; if (dirty !== 1'b1) begin errors++; $display("FAIL addr_dirty got %b exp 1", dirty); end
    checks++; if (ptr !== 3'd0) begin errors++; $display("FAIL addr_ptr got %0d exp 0", ptr); end
    commit = 1'b1;
    tick();
    commit = 1'b0;
    checks++; if (dvec !== 32'h87A54321) begin errors++; $display("FAIL addr_commit_D got %h exp 87A54321", dvec); end
    checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL addr_commit_dirty got %b exp 0", dirty); end
    checks++; if (ptr !== 3'd0) begin errors++; $display("FAIL addr_commit_ptr got %0d exp 0", ptr); end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL addr_commit_fd got %b exp 1", frame_done); end
  endtask

  task automatic test_write_commit();
    wr_en = 1'b1; wr_auto = 1'b0; wr_addr = 3'd2; wr_data = 4'hF; commit = 1'b1;
    tick();
    idle_inputs();
    checks++; if (dvec !== 32'h87A54F21) begin errors++; $display("FAIL bypass_D got %h exp 87A54F21", dvec); end
    checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL bypass_dirty got %b exp 0", dirty); end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL bypass_fd got %b exp 1", frame_done); end
    tick();
    // idempotent commit still pulses and leaves D alone
    commit = 1'b1;
    tick();
    commit = 1'b0;
    checks++; if (dvec !== 32'h87A54F21 || frame_done !== 1'b1) begin
      errors++; $display("FAIL idem_commit got D=%h fd=%b exp D=87A54F21 fd=1", dvec, frame_done);
    end
  endtask

  task automatic test_clear();
    wr_en = 1'b1; wr_auto = 1'b1; wr_data = 4'h3;
    tick();
    wr_data = 4'h4;
    tick();
    checks++; if (ptr !== 3'd2) begin errors++; $display("FAIL pre_clear_ptr got %0d exp 2", ptr); end
    wr_en = 1'b1; wr_auto = 1'b0; wr_addr = 3'd3; wr_data = 4'h7; clear = 1'b1;
    tick();
    idle_inputs();
    checks++; if (dvec !== 32'h87A54F21) begin errors++; $display("FAIL clear_D got %h exp 87A54F21", dvec); end
    checks++; if (ptr !== 3'd0) begin errors++; $display("FAIL clear_ptr got %0d exp 0", ptr); end
    checks++; if (dirty !== 1'b1) begin errors++; $display("FAIL clear_dirty got %b exp 1", dirty); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL clear_fd got %b exp 0", frame_done); end
    commit = 1'b1;
    tick();
    commit = 1'b0;
    checks++; if (dvec !== 32'h0) begin errors++; $display("FAIL clear_commit_D got %h exp 0", dvec); end
    checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL clear_commit_dirty got %b exp 0", dirty); end
  endtask

  task automatic test_reset_mid_frame();
    wr_en = 1'b1; wr_auto = 1'b0; wr_addr = 3'd7; wr_data = 4'h5; commit = 1'b1;
    tick();
    idle_inputs();
    checks++; if (dvec !== 32'h50000000) begin errors++; $display("FAIL pre_rst_D got %h exp 50000000", dvec); end
    for (int k = 0; k < 3; k++) begin
      wr_en = 1'b1; wr_auto = 1'b1; wr_data = 4'(k + 1);
      tick();
    end
    idle_inputs();
    checks++; if (ptr !== 3'd3) begin errors++; $display("FAIL mid_ptr got %0d exp 3", ptr); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (ptr !== 3'd0 || dvec !== 32'h0 || dirty !== 1'b0) begin
      errors++; $display("FAIL mid_rst got ptr=%0d D=%h dirty=%b exp ptr=0 D=0 dirty=0", ptr, dvec, dirty);
    end
    wr_en = 1'b1; wr_auto = 1'b1; wr_data = 4'h9;
    tick();
    idle_inputs();
    checks++; if (ptr !== 3'd1 || dvec !== 32'h0) begin
      errors++; $display("FAIL post_rst_write got ptr=%0d D=%h exp ptr=1 D=0", ptr, dvec);
    end
    commit = 1'b1;
    tick();
    commit = 1'b0;
    checks++; if (dvec !== 32'h00000009) begin errors++; $display("FAIL post_rst_commit got %h exp 00000009", dvec); end
  endtask

  initial begin
    test_reset();
    test_auto_frame();
    test_addr_commit();
    test_write_commit();
    test_clear();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux18_loader.md
Name: demux18_loader

Overview:
Writer side of the 8-slot nibble selection path. It accepts a stream of 4-bit values and distributes them into eight slots, D0..D7, which feed the downstream 8:1 selector. A shadow bank collects writes. An output bank drives D0..D7 and changes only on commit, so the downstream selector never shows a half-written frame. Writes can be addressed (explicit slot index) or auto-incrementing (internal pointer).

Parameters:
WIDTH, 4, bit width of each slot value
RESET_VAL, 0, value loaded into every shadow and output slot on reset/clear

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous reset, active-high
wr_en  input  1  write strobe; one slot written per cycle it is high
wr_auto  input  1  1 = target slot is internal ptr; 0 = target slot is wr_addr
wr_addr  input  3  slot index for addressed writes
wr_data  input  WIDTH  value to write
commit  input  1  copy shadow bank to output bank
clear  input  1  reload shadow bank with RESET_VAL, ptr to 0
D0..D7  output  WIDTH each  output bank, registered
ptr  output  3  current auto-increment pointer
dirty  output  1  shadow bank differs from output bank (written/cleared since last commit)
frame_done  output  1  one-cycle pulse after any output-bank update

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: shadow[0..7] = RESET_VAL, D0..D7 = RESET_VAL, ptr = 0, dirty = 0, frame_done = 0.
- Priority at each edge: rst > clear > write. Commit is evaluated alongside clear/write, not instead of them.
- Write (wr_en=1, clear=0):
  - target = wr_auto ? ptr : wr_addr.
  - shadow[target] <= wr_data; dirty <= 1.
  - If wr_auto: ptr <= ptr+1, wrapping 7 -> 0.
  - Addressed writes leave ptr unchanged.
- Auto frame end: an auto write with ptr==7 is an implicit commit in the same edge.
- Commit (commit=1, or implicit):
  - The output bank loads the shadow bank, with any same-edge write merged in (write-through bypass).
  - The new value is therefore visible on Dx after the same edge that sampled the write: 1-cycle latency from the input.
  - dirty <= 0.
  - frame_done <= 1 for exactly the next cycle; otherwise frame_done <= 0.
- Clear (clear=1):
  - shadow[*] <= RESET_VAL, ptr <= 0; any concurrent wr_en is ignored.
  - dirty <= 1 if no commit in the same edge.
  - clear with commit: output bank <= RESET_VAL in all slots, dirty <= 0, frame_done pulses.
- commit with no write: output bank <= shadow unchanged; a pulse is still produced (an idempotent commit is legal).
- Output bank never changes except on commit or rst.
- wr_addr is ignored when wr_auto=1; wr_auto and wr_addr are ignored when wr_en=0.
- Back-to-back auto writes every cycle are supported at full rate: 8 writes -> 1 commit -> frame_done, then ptr=0 for the next frame.
- rst mid-frame discards partial shadow contents and ptr; the next auto write goes to slot 0.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package holds: SLOTS=8, PTR_W=3, default WIDTH=4, and a slot-index type shared with the downstream selector so both agree on encoding (000=D0 ... 111=D7).
- One sub-module, dec38_we: a 3-to-8 one-hot write-enable decoder, gated by the effective write enable. It drives both the shadow-slot enables and the bypass merge.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> D0..D7=0, ptr=0, dirty=0, frame_done=0; all remain so for 10 idle cycles.
- Auto frame:
  - Stimulus: wr_auto=1, wr_en=1 for 8 consecutive cycles with data 1,2,...,8.
  - D0..D7 stay 0 through the first 7 writes, dirty=1.
  - After the 8th edge: D0..D7=1..8, ptr=0, dirty=0, frame_done=1 for exactly one cycle.
- Addressed write + commit:
  - Stimulus: write 4'hA to addr 5; D5 stays at its old value.
  - Next cycle, commit=1: D5=A, dirty 1->0, ptr unchanged.
- Same-edge write+commit: addressed write 4'hF to addr 2 with commit=1 -> D2=F after that same edge (bypass), dirty=0.
- Clear priority:
  - clear=1 with wr_en=1 (data 7, addr 3) -> shadow all 0, write dropped, ptr=0, dirty=1, D unchanged.
  - Following commit -> D0..D7 all 0.
- Reset mid-frame: after 3 auto writes (ptr=3), pulse rst -> ptr=0, D all 0; the next auto write of 9 lands in slot 0, confirmed by a later commit (D0=9).
